// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Time-multiplexed digit scan controller driving a 3-to-8 active-low decoder
//   (G1 / G2A / G2B enables plus 3-bit address). It steps round-robin through
//   the digits enabled in digit_mask. Each digit is driven for DIV cycles. A
//   BLANK-cycle gap with the decoder off comes before every slot so that the
//   address never changes while a common is driven.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low forces IDLE and abandons the current slot
//   digit_mask  bit i set -> digit i takes part in the scan
//   G1          decoder enable, active-high
//   G2A, G2B    decoder enables, active-low
//   address     decoder address (current digit index)
//   slot_start  one-cycle pulse on the first cycle of each drive slot
//   busy        high whenever the controller is not idle
module decoder_scan_ctrl #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2,
  parameter int CW    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
  output logic       G1,
  output logic       G2A,
  output logic       G2B,
  output logic [2:0] address,
  output logic       slot_start,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LP_DIV_TERM   = CW'(DIV - 1);
  localparam logic [CW-1:0] LP_BLANK_TERM = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam bit            LP_HAS_BLANK  = (BLANK > 0);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_g1;
  logic          r_g2;
  logic [2:0]    r_addr;
  logic          r_slot_start;
  logic          r_busy;

  logic [2:0]    w_lowest;
  logic [2:0]    w_next;

  // Lowest set bit of the mask. The loop runs downward, so the last hit is
  // the smallest index.
  always_comb begin
    w_lowest = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (digit_mask[i-1]) w_lowest = 3'(i - 1);
    end
  end

  // First set bit searching upward from address+1 with wrap. Offset 8 maps
  // back to the current digit, so a lone digit reselects itself.
  always_comb begin
    w_next = r_addr;
    for (int unsigned i = 8; i > 0; i--) begin
      if (digit_mask[r_addr + 3'(i)]) w_next = r_addr + 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_g1         <= 1'b0;
      r_g2         <= 1'b1;
      r_addr       <= '0;
      r_slot_start <= 1'b0;
      r_busy       <= 1'b0;
    end else if (!en) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_g1         <= 1'b0;
      r_g2         <= 1'b1;
      r_slot_start <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_slot_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (digit_mask != 8'h00) begin
            r_addr <= w_lowest;
            r_busy <= 1'b1;
            if (LP_HAS_BLANK) begin
              r_state <= S_BLANK;
            end else begin
              r_state      <= S_DRIVE;
              r_g1         <= 1'b1;
              r_g2         <= 1'b0;
              r_slot_start <= 1'b1;
            end
          end
        end

        S_BLANK: begin
          if (r_cnt == LP_BLANK_TERM) begin
            r_cnt        <= '0;
            r_state      <= S_DRIVE;
            r_g1         <= 1'b1;
            r_g2         <= 1'b0;
            r_slot_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DRIVE: begin
          if (r_cnt == LP_DIV_TERM) begin
            r_cnt <= '0;
            if (digit_mask == 8'h00) begin
              r_state <= S_IDLE;
              r_g1    <= 1'b0;
              r_g2    <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_addr <= w_next;
              if (LP_HAS_BLANK) begin
                r_state <= S_BLANK;
                r_g1    <= 1'b0;
                r_g2    <= 1'b1;
              end else begin
                // Back-to-back slots: decoder stays on, new slot pulse.
                r_state      <= S_DRIVE;
                r_slot_start <= 1'b1;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_g1    <= 1'b0;
          r_g2    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign G1         = r_g1;
  assign G2A        = r_g2;
  assign G2B        = r_g2;
  assign address    = r_addr;
  assign slot_start = r_slot_start;
  assign busy       = r_busy;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl. Instance A uses DIV=4, BLANK=1.
// Instance B uses DIV=1, BLANK=0. Every output vector is packed as
// {G1, G2A, G2B, address[2:0], slot_start, busy}.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [7:0] mask;
  logic       g1, g2a, g2b, ss, busy;
  logic [2:0] addr;

  logic       rst_n_b, en_b;
  logic [7:0] mask_b;
  logic       g1_b, g2a_b, g2b_b, ss_b, busy_b;
  logic [2:0] addr_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV(4), .BLANK(1), .CW(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_mask(mask),
    .G1(g1), .G2A(g2a), .G2B(g2b), .address(addr),
    .slot_start(ss), .busy(busy)
  );

  decoder_scan_ctrl #(.DIV(1), .BLANK(0), .CW(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .digit_mask(mask_b),
    .G1(g1_b), .G2A(g2a_b), .G2B(g2b_b), .address(addr_b),
    .slot_start(ss_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] exp);
    chk(tag, {g1, g2a, g2b, addr, ss, busy}, exp);
  endtask

  task automatic chk_b(input string tag, input logic [7:0] exp);
    chk(tag, {g1_b, g2a_b, g2b_b, addr_b, ss_b, busy_b}, exp);
  endtask

  // One blank cycle plus four drive cycles at digit a. When the drive index
  // equals act_at, the bench applies mask/en (act_at < 0 means no change).
  task automatic slot(input logic [2:0] a, input int act_at,
                      input logic [7:0] am, input logic ae);
    step();
    chk_a("blank", {3'b011, a, 1'b0, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a("drive", {3'b100, a, (i == 0), 1'b1});
      if (i == act_at) begin
        mask = am;
        en   = ae;
      end
    end
  endtask

  task automatic idle_a(input logic [2:0] a);
    step();
    chk_a("idle", {3'b011, a, 1'b0, 1'b0});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mask = 8'h00;
    rst_n_b = 1'b0; en_b = 1'b0; mask_b = 8'h00;
    #12;
    chk_a("reset_a", 8'b011_000_0_0);
    chk_b("reset_b", 8'b011_000_0_0);
    step();
    rst_n = 1'b1;
    idle_a(3'd0);

    // Full mask: 0..7 then wrap to 0.
    mask = 8'hFF; en = 1'b1;
    for (int d = 0; d < 8; d++) slot(3'(d), -1, 8'h00, 1'b1);
    slot(3'd0, -1, 8'h00, 1'b1);
    en = 1'b0;
    idle_a(3'd0);

    // Sparse mask with wrap 7->0.
    mask = 8'b1000_0101; en = 1'b1;
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd2, -1, 8'h00, 1'b1);
    slot(3'd7, -1, 8'h00, 1'b1);
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd2, -1, 8'h00, 1'b1);
    en = 1'b0;
    idle_a(3'd2);

    // Single digit reselects itself.
    mask = 8'b0001_0000; en = 1'b1;
    slot(3'd4, -1, 8'h00, 1'b1);
    slot(3'd4, -1, 8'h00, 1'b1);
    slot(3'd4, -1, 8'h00, 1'b1);
    en = 1'b0;
    idle_a(3'd4);

    // Mask changes FF->01 during slot 3: slot completes, then digit 0.
    mask = 8'hFF; en = 1'b1;
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd1, -1, 8'h00, 1'b1);
    slot(3'd2, -1, 8'h00, 1'b1);
    slot(3'd3, 0, 8'h01, 1'b1);
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd0, -1, 8'h00, 1'b1);
    en = 1'b0;
    idle_a(3'd0);

    // Mask goes to 0 during slot 3: IDLE after the slot, address holds.
    mask = 8'hFF; en = 1'b1;
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd1, -1, 8'h00, 1'b1);
    slot(3'd2, -1, 8'h00, 1'b1);
    slot(3'd3, 1, 8'h00, 1'b1);
    idle_a(3'd3);
    idle_a(3'd3);
    en = 1'b0;
    idle_a(3'd3);

    // Drop en in the 2nd drive cycle of digit 5, then restart from digit 0.
    mask = 8'hFF; en = 1'b1;
    for (int d = 0; d < 5; d++) slot(3'(d), -1, 8'h00, 1'b1);
    step();
    chk_a("blank5", 8'b011_101_0_1);
    step();
    chk_a("drive5_0", 8'b100_101_1_1);
    step();
    chk_a("drive5_1", 8'b100_101_0_1);
    en = 1'b0;
    idle_a(3'd5);
    en = 1'b1;
    slot(3'd0, -1, 8'h00, 1'b1);
    slot(3'd1, -1, 8'h00, 1'b1);

    // Instance B: DIV=1, BLANK=0 -> decoder on every cycle, continuous pulse.
    rst_n_b = 1'b1;
    step();
    chk_b("b_idle", 8'b011_000_0_0);
    mask_b = 8'hFF; en_b = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk_b("b_drive", {3'b100, 3'(c), 1'b1, 1'b1});
    end

    // Asynchronous reset between edges.
    #3;
    rst_n_b = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_b("b_async_rst", 8'b011_000_0_0);
    chk_a("a_async_rst", 8'b011_000_0_0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
